delay_buffer_sched: RTL

Frame-level scheduler for a fixed-latency `delay_buffer_0d` instance. It accepts a frame of `FRAME_LEN` samples over a ready/valid input and pushes accepted samples into the delay buffer. It tracks which delay-buffer outputs are valid with a shadow valid pipe, and throttles acceptance with a credit counter so downstream storage never overflows. It sits between a stream producer and a downstream FIFO in the linear-layer datapath, and signals frame completion once the last sample has left the delay line.

---
 rtl/delay_buffer_sched_if.sv | 27 ++
 rtl/delay_buffer_sched.sv | 121 ++++++++++++
 2 files changed

// File: rtl/delay_buffer_sched_if.sv
// Stream-side signals of delay_buffer_sched: producer input, delay-line output and credit return.
// out_last exists only when DELAY_BUFFER_SCHED_LAST_EN is defined.
interface delay_buffer_sched_if #(
  parameter int PRECISION = 8
);
  logic [PRECISION-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [PRECISION-1:0] out_data;
  logic                 out_valid;
`ifdef DELAY_BUFFER_SCHED_LAST_EN
  logic                 out_last;
`endif
  logic                 credit_return;

`ifdef DELAY_BUFFER_SCHED_LAST_EN
  modport master (output in_data, in_valid, credit_return,
                  input  in_ready, out_data, out_valid, out_last);
  modport slave  (input  in_data, in_valid, credit_return,
                  output in_ready, out_data, out_valid, out_last);
`else
  modport master (output in_data, in_valid, credit_return,
                  input  in_ready, out_data, out_valid);
  modport slave  (input  in_data, in_valid, credit_return,
                  output in_ready, out_data, out_valid);
`endif
endinterface

// File: rtl/delay_buffer_sched.sv
// Frame scheduler for a fixed-latency delay buffer: credit-throttled intake, shadow valid pipe, done pulse.
// Optional per-sample last flag on the output is enabled by defining DELAY_BUFFER_SCHED_LAST_EN.
module delay_buffer_sched #(
  parameter int PRECISION = 8,
  parameter int DELAY     = 4,
  parameter int FRAME_LEN = 16,
  parameter int CREDITS   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  delay_buffer_sched_if.slave              sif,
  output logic [PRECISION-1:0]             buf_idata,
  input  logic [PRECISION-1:0]             buf_odata,
  output logic [1:0]                       state_dbg,
  output logic [$clog2(CREDITS+1)-1:0]     credits_dbg
);

  localparam int BW = $clog2(FRAME_LEN + 1);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [BW-1:0] FRAME_BEATS  = BW'(FRAME_LEN);
  localparam logic [BW-1:0] LAST_BEAT    = BW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] CREDITS_FULL = CW'(CREDITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [BW-1:0] beat_cnt;
  logic [CW-1:0] credits;
  logic          accept;
  logic          last_beat;
  logic          pipe_empty;

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready; in_ready never
  // depends on in_valid, and the producer must hold in_data while in_valid && !in_ready.
  assign sif.in_ready = (state == RUN) && (credits != '0) && (beat_cnt < FRAME_BEATS);
  assign accept       = sif.in_valid && sif.in_ready;
  assign last_beat    = accept && (beat_cnt == LAST_BEAT);
  assign buf_idata    = accept ? sif.in_data : '0;
  assign sif.out_data = buf_odata;
  assign busy         = (state != IDLE);
  assign state_dbg    = state;
  assign credits_dbg  = credits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_beat) state_nx = DRAIN;
      DRAIN: begin
        if (pipe_empty) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        beat_cnt <= '0;
    else if (state == IDLE && start) beat_cnt <= '0;
    else if (accept)                beat_cnt <= beat_cnt + 1'b1;
  end

  // Credits survive across frames; a return at full count is dropped rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CREDITS_FULL;
    end else if (accept && !sif.credit_return) begin
      credits <= credits - 1'b1;
    end else if (!accept && sif.credit_return && (credits != CREDITS_FULL)) begin
      credits <= credits + 1'b1;
    end
  end

  generate
    if (DELAY > 0) begin : g_pipe
      logic [DELAY-1:0] vpipe;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) vpipe <= '0;
        else     vpipe <= (vpipe << 1) | DELAY'(accept);
      end

      assign pipe_empty    = (vpipe == '0);
      assign sif.out_valid = vpipe[DELAY-1];

`ifdef DELAY_BUFFER_SCHED_LAST_EN
      logic [DELAY-1:0] lpipe;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) lpipe <= '0;
        else     lpipe <= (lpipe << 1) | DELAY'(last_beat);
      end

      assign sif.out_last = lpipe[DELAY-1];
`endif
    end else begin : g_nopipe
      // Zero-latency buffer: the sample leaves in its acceptance cycle, nothing stays in flight.
      assign pipe_empty    = 1'b1;
      assign sif.out_valid = accept;
`ifdef DELAY_BUFFER_SCHED_LAST_EN
      assign sif.out_last  = last_beat;
`endif
    end
  endgenerate

endmodule
